// File: rtl/pwm_multichannel_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
//   pwm_state_e : controller states (IDLE, RUN, STOP)
//   EDGE/CENTER : alignment mode encodings as seen on center_mode
//   DIR_UP/DIR_DOWN : period counter direction encodings
package pwm_multichannel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } pwm_state_e;

    localparam logic EDGE   = 1'b0;
    localparam logic CENTER = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_multichannel_prescaler.sv
// Prescaler for the PWM period counter: a down-counter that issues a tick
// when it reaches zero and then reloads, so the counter advances once every
// reload+1 clk cycles.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   restart    : load the down-counter with reload (start of a run)
//   run        : count while high; hold otherwise
//   reload     : reload value (active prescale)
//   tick       : one-cycle advance strobe for the period counter
module pwm_prescaler #(
    parameter int PRESC_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   restart,
    input  logic                   run,
    input  logic [PRESC_WIDTH-1:0] reload,
    output logic                   tick
);

    localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1);

    logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;

    // Kept separate from the next-count logic so the reload mux in the
    // parent (which depends on tick) never forms a combinational loop.
    assign tick = run && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = reload;
        end else if (run) begin
            if (cnt_q == '0) begin
                cnt_d = reload;
            end else begin
                cnt_d = cnt_q - PRESC_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator. All channels share one prescaler, one period
// counter and one alignment mode; each channel has its own duty value.
// Configuration is double-buffered in shadow registers and only applied at a
// period boundary (or immediately while idle), so outputs never glitch.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   start       : level run enable; dropping it finishes the current period
//   prescale    : counter advances every prescale+1 clk cycles
//   period      : terminal count of the period counter
//   duty        : packed per-channel duty, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   center_mode : 0 = edge-aligned, 1 = center-aligned
//   cfg_load    : one-cycle pulse capturing all config inputs into the shadow
//   cfg_pending : shadow holds values not yet applied
//   period_tick : one-cycle pulse at each period boundary
//   pwm_out     : registered PWM outputs
//   busy        : controller is not idle
//
// state | meaning
// IDLE  | stopped, outputs forced low, pending config applied at once
// RUN   | counting, config applied at each period boundary
// STOP  | finishing the current period; back to RUN if start returns
module pwm_multichannel
    import pwm_multichannel_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int PRESC_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [PRESC_WIDTH-1:0]      prescale,
    input  logic [CNT_WIDTH-1:0]        period,
    input  logic [NUM_CH*CNT_WIDTH-1:0] duty,
    input  logic                        center_mode,
    input  logic                        cfg_load,
    output logic                        cfg_pending,
    output logic                        period_tick,
    output logic [NUM_CH-1:0]           pwm_out,
    output logic                        busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    pwm_state_e state_q, state_d;

    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic                        dir_q, dir_d;

    logic [PRESC_WIDTH-1:0]      act_prescale_q, act_prescale_d;
    logic [CNT_WIDTH-1:0]        act_period_q, act_period_d;
    logic [NUM_CH*CNT_WIDTH-1:0] act_duty_q, act_duty_d;
    logic                        act_center_q, act_center_d;

    logic [PRESC_WIDTH-1:0]      sh_prescale_q, sh_prescale_d;
    logic [CNT_WIDTH-1:0]        sh_period_q, sh_period_d;
    logic [NUM_CH*CNT_WIDTH-1:0] sh_duty_q, sh_duty_d;
    logic                        sh_center_q, sh_center_d;
    logic                        cfg_pending_q, cfg_pending_d;

    logic                        period_tick_q, period_tick_d;
    logic [NUM_CH-1:0]           pwm_out_q, pwm_out_d;
    logic [NUM_CH-1:0]           raw;

    logic                        presc_tick;
    logic                        presc_restart;
    logic                        presc_run;
    logic [PRESC_WIDTH-1:0]      presc_reload;
    logic                        boundary;
    logic                        apply;

    // The shadow is copied on the same edge the boundary is reached, so the
    // prescaler reload on that edge must already use the incoming value.
    assign apply         = cfg_pending_q && ((state_q == IDLE) || boundary);
    assign presc_reload  = apply ? sh_prescale_q : act_prescale_q;
    assign presc_restart = (state_q == IDLE) && start;
    assign presc_run     = (state_q != IDLE);

    pwm_prescaler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .restart (presc_restart),
        .run     (presc_run),
        .reload  (presc_reload),
        .tick    (presc_tick)
    );

    // Period counter. Center mode walks 0..period..1 and the boundary is the
    // step that lands on 0 going down; period=0 degenerates to edge mode.
    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        boundary = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (presc_tick) begin
            if ((act_center_q == EDGE) || (act_period_q == '0)) begin
                dir_d = DIR_UP;
                if (cnt_q >= act_period_q) begin
                    cnt_d    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else if (dir_q == DIR_UP) begin
                if (cnt_q >= act_period_q) begin
                    cnt_d = act_period_q - CNT_ONE;
                    // period=1: turning around already lands on 0
                    if (act_period_q == CNT_ONE) begin
                        boundary = 1'b1;
                    end else begin
                        dir_d = DIR_DOWN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                if (cnt_q <= CNT_ONE) begin
                    cnt_d    = '0;
                    dir_d    = DIR_UP;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        end
    end

    // A cfg_load that coincides with a boundary still captures into the
    // shadow; the old shadow is what gets applied, and pending stays set.
    always_comb begin
        sh_prescale_d  = sh_prescale_q;
        sh_period_d    = sh_period_q;
        sh_duty_d      = sh_duty_q;
        sh_center_d    = sh_center_q;
        act_prescale_d = act_prescale_q;
        act_period_d   = act_period_q;
        act_duty_d     = act_duty_q;
        act_center_d   = act_center_q;
        cfg_pending_d  = cfg_pending_q && !apply;
        if (apply) begin
            act_prescale_d = sh_prescale_q;
            act_period_d   = sh_period_q;
            act_duty_d     = sh_duty_q;
            act_center_d   = sh_center_q;
        end
        if (cfg_load) begin
            sh_prescale_d = prescale;
            sh_period_d   = period;
            sh_duty_d     = duty;
            sh_center_d   = center_mode;
            cfg_pending_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!start) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (start) begin
                    state_d = RUN;
                end else if (boundary) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign raw[i] = (cnt_q < act_duty_q[i*CNT_WIDTH +: CNT_WIDTH]);
    end

    always_comb begin
        period_tick_d = boundary;
        pwm_out_d     = (state_q == IDLE) ? '0 : raw;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            dir_q          <= DIR_UP;
            act_prescale_q <= '0;
            act_period_q   <= '0;
            act_duty_q     <= '0;
            act_center_q   <= EDGE;
            sh_prescale_q  <= '0;
            sh_period_q    <= '0;
            sh_duty_q      <= '0;
            sh_center_q    <= EDGE;
            cfg_pending_q  <= 1'b0;
            period_tick_q  <= 1'b0;
            pwm_out_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            act_prescale_q <= act_prescale_d;
            act_period_q   <= act_period_d;
            act_duty_q     <= act_duty_d;
            act_center_q   <= act_center_d;
            sh_prescale_q  <= sh_prescale_d;
            sh_period_q    <= sh_period_d;
            sh_duty_q      <= sh_duty_d;
            sh_center_q    <= sh_center_d;
            cfg_pending_q  <= cfg_pending_d;
            period_tick_q  <= period_tick_d;
            pwm_out_q      <= pwm_out_d;
        end
    end

    assign cfg_pending = cfg_pending_q;
    assign period_tick = period_tick_q;
    assign pwm_out     = pwm_out_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_multichannel.sv
module tb_pwm_multichannel;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] prescale;
    logic [7:0]  period;
    logic [31:0] duty;
    logic        center_mode;
    logic        cfg_load;
    logic        cfg_pending;
    logic        period_tick;
    logic [3:0]  pwm_out;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int w;
    int ticks;
    int highs [4];
    logic [31:0] pat;

    always #5 clk = ~clk;

    pwm_multichannel #(
        .NUM_CH      (4),
        .CNT_WIDTH   (8),
        .PRESC_WIDTH (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .prescale    (prescale),
        .period      (period),
        .duty        (duty),
        .center_mode (center_mode),
        .cfg_load    (cfg_load),
        .cfg_pending (cfg_pending),
        .period_tick (period_tick),
        .pwm_out     (pwm_out),
        .busy        (busy)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steps until period_tick is seen (or the budget runs out); w = cycles waited.
    task automatic wait_tick(input int budget, input string tag);
        w = 0;
        do begin
            step(1);
            w++;
        end while (!period_tick && (w < budget));
        chk(tag, 32'(period_tick), 32'd1);
    endtask

    // Samples n cycles starting with the current one; counts highs and ticks,
    // and records channel ch bit-per-cycle in pat.
    task automatic measure(input int n, input int ch);
        ticks = 0;
        pat   = '0;
        for (int c = 0; c < 4; c++) highs[c] = 0;
        for (int k = 0; k < n; k++) begin
            if (period_tick) ticks++;
            for (int c = 0; c < 4; c++) if (pwm_out[c]) highs[c]++;
            pat[k] = pwm_out[ch];
            step(1);
        end
    endtask

    task automatic load_cfg(input logic [15:0] ps, input logic [7:0] per,
                            input logic [31:0] dt, input logic cm);
        prescale    = ps;
        period      = per;
        duty        = dt;
        center_mode = cm;
        cfg_load    = 1'b1;
        step(1);
        cfg_load    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; center_mode = 1'b0; cfg_load = 1'b0;
        prescale = '0; period = '0; duty = '0;
        step(2);
        chk("rst_pwm",     32'(pwm_out),     32'd0);
        chk("rst_busy",    32'(busy),        32'd0);
        chk("rst_tick",    32'(period_tick), 32'd0);
        chk("rst_pending", 32'(cfg_pending), 32'd0);
        reset = 1'b0;
        step(1);

        // Edge mode, period 9, duties 0/3/10/15
        load_cfg(16'd0, 8'd9, {8'd15, 8'd10, 8'd3, 8'd0}, 1'b0);
        chk("idle_load_pending", 32'(cfg_pending), 32'd1);
        step(1);
        chk("idle_apply_pending", 32'(cfg_pending), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        step(1);
        chk("run_busy", 32'(busy), 32'd1);
        wait_tick(20, "edge_first_tick");
        wait_tick(20, "edge_second_tick");
        chk("edge_interval", 32'(w), 32'd10);
        measure(10, 1);
        chk("edge_ticks", 32'(ticks), 32'd1);
        chk("edge_hi0", 32'(highs[0]), 32'd0);
        chk("edge_hi1", 32'(highs[1]), 32'd3);
        chk("edge_hi2", 32'(highs[2]), 32'd10);
        chk("edge_hi3", 32'(highs[3]), 32'd10);
        chk("edge_pat1", pat, 32'h0000_000E);

        // Center mode, period 4, duties 2/5/0/4
        load_cfg(16'd0, 8'd4, {8'd4, 8'd0, 8'd5, 8'd2}, 1'b1);
        wait_tick(20, "center_apply_tick");
        chk("center_apply_wait", 32'(w), 32'd9);
        wait_tick(20, "center_tick");
        chk("center_interval", 32'(w), 32'd8);
        measure(8, 0);
        chk("center_ticks", 32'(ticks), 32'd1);
        chk("center_hi0", 32'(highs[0]), 32'd3);
        chk("center_hi1", 32'(highs[1]), 32'd8);
        chk("center_hi2", 32'(highs[2]), 32'd0);
        chk("center_hi3", 32'(highs[3]), 32'd7);
        chk("center_pat0", pat, 32'h0000_0007);

        // Prescale 2, period 3, edge mode, duties 2/1/4/0
        load_cfg(16'd2, 8'd3, {8'd0, 8'd4, 8'd1, 8'd2}, 1'b0);
        wait_tick(20, "presc_apply_tick");
        chk("presc_apply_wait", 32'(w), 32'd7);
        wait_tick(30, "presc_tick");
        chk("presc_interval", 32'(w), 32'd12);
        measure(12, 0);
        chk("presc_ticks", 32'(ticks), 32'd1);
        chk("presc_hi0", 32'(highs[0]), 32'd6);
        chk("presc_hi1", 32'(highs[1]), 32'd3);
        chk("presc_hi2", 32'(highs[2]), 32'd12);
        chk("presc_hi3", 32'(highs[3]), 32'd0);
        chk("presc_pat0", pat, 32'h0000_007E);

        // Mid-period duty change 2 -> 6
        load_cfg(16'd0, 8'd9, {4{8'd2}}, 1'b0);
        wait_tick(30, "dc_apply_tick");
        wait_tick(20, "dc_tick");
        chk("dc_interval", 32'(w), 32'd10);
        step(4);
        load_cfg(16'd0, 8'd9, {4{8'd6}}, 1'b0);
        chk("dc_pending_set", 32'(cfg_pending), 32'd1);
        step(1);
        chk("dc_old_duty", 32'(pwm_out), 32'd0);
        chk("dc_pending_hold", 32'(cfg_pending), 32'd1);
        step(4);
        chk("dc_boundary_tick", 32'(period_tick), 32'd1);
        chk("dc_pending_clr", 32'(cfg_pending), 32'd0);
        measure(10, 0);
        chk("dc_new_hi0", 32'(highs[0]), 32'd6);
        chk("dc_new_ticks", 32'(ticks), 32'd1);

        // cfg_load on the boundary: previous shadow applied, new one pending
        step(2);
        load_cfg(16'd0, 8'd9, {4{8'd1}}, 1'b0);
        step(6);
        prescale = 16'd0; period = 8'd9; duty = {4{8'd4}}; center_mode = 1'b0;
        cfg_load = 1'b1;
        step(1);
        cfg_load = 1'b0;
        chk("coin_tick", 32'(period_tick), 32'd1);
        chk("coin_pending", 32'(cfg_pending), 32'd1);
        measure(10, 0);
        chk("coin_first_hi0", 32'(highs[0]), 32'd1);
        chk("coin_next_tick", 32'(period_tick), 32'd1);
        chk("coin_pending_clr", 32'(cfg_pending), 32'd0);
        measure(10, 0);
        chk("coin_second_hi0", 32'(highs[0]), 32'd4);

        // Stop mid-period: period completes, then idle
        step(4);
        start = 1'b0;
        step(1);
        chk("stop_busy", 32'(busy), 32'd1);
        wait_tick(20, "stop_final_tick");
        chk("stop_wait", 32'(w), 32'd5);
        chk("stop_idle_busy", 32'(busy), 32'd0);
        step(1);
        chk("stop_idle_pwm", 32'(pwm_out), 32'd0);
        measure(20, 0);
        chk("idle_no_ticks", 32'(ticks), 32'd0);
        chk("idle_no_high", 32'(highs[0] + highs[1] + highs[2] + highs[3]), 32'd0);

        // Restart, then drop and restore start before the boundary
        start = 1'b1;
        wait_tick(20, "restart_tick");
        chk("restart_wait", 32'(w), 32'd11);
        step(3);
        start = 1'b0;
        step(1);
        chk("resume_stop_busy", 32'(busy), 32'd1);
        step(2);
        start = 1'b1;
        wait_tick(20, "resume_tick");
        chk("resume_wait", 32'(w), 32'd4);
        wait_tick(20, "resume_next_tick");
        chk("resume_no_gap", 32'(w), 32'd10);
        chk("resume_busy", 32'(busy), 32'd1);

        // Reset mid-period with a pending shadow
        step(3);
        load_cfg(16'd0, 8'd5, {4{8'd7}}, 1'b0);
        chk("rst2_pending_before", 32'(cfg_pending), 32'd1);
        reset = 1'b1;
        start = 1'b0;
        step(1);
        chk("rst2_pwm",     32'(pwm_out),         32'd0);
        chk("rst2_busy",    32'(busy),            32'd0);
        chk("rst2_tick",    32'(period_tick),     32'd0);
        chk("rst2_pending", 32'(cfg_pending),     32'd0);
        chk("rst2_sh_duty", 32'(dut.sh_duty_q),   32'd0);
        chk("rst2_sh_per",  32'(dut.sh_period_q), 32'd0);
        reset = 1'b0;
        step(1);
        chk("rst2_idle", 32'(busy), 32'd0);

        // Cleared active config: period 0, prescale 0 -> tick every clk, outputs low
        start = 1'b1;
        wait_tick(10, "zero_first_tick");
        chk("zero_first_wait", 32'(w), 32'd2);
        wait_tick(10, "zero_next_tick");
        chk("zero_interval", 32'(w), 32'd1);
        chk("zero_pwm", 32'(pwm_out), 32'd0);
        start = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
